// File: rtl/fault_chk_pkg.sv
// Shared types and constants for the fault-response checker: FSM states,
// MISR feedback polynomial, "no mismatch" marker and default parameter values.
package fault_chk_pkg;

    localparam int RESP_W_DEF = 28;
    localparam int STEPS_DEF  = 256;
    localparam int FID_W_DEF  = 16;

    localparam logic [27:0] MISR_POLY   = 28'h0000009;
    localparam logic [8:0]  NO_MISMATCH = 9'h100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOLD,
        ST_RUN,
        ST_REPORT
    } state_e;

endpackage

// File: rtl/resp_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through the
// polynomial, xor in the response. load_seed restarts the signature from zero.
module resp_misr
    import fault_chk_pkg::*;
#(
    parameter int W = RESP_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_seed,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    localparam logic [W-1:0] POLY = W'(MISR_POLY);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;
    logic [W-1:0] base;

    always_comb begin
        base  = load_seed ? '0 : sig_q;
        sig_d = sig_q;
        if (en) begin
            sig_d = {base[W-2:0], 1'b0} ^ (base[W-1] ? POLY : '0) ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/fault_resp_checker.sv
// Compares per-pattern fault-simulation responses against a stored golden table,
// compacts them into a MISR and emits one result record per fault pass.
module fault_resp_checker
    import fault_chk_pkg::*;
#(
    parameter int RESP_W = RESP_W_DEF,
    parameter int STEPS  = STEPS_DEF,
    parameter int FID_W  = FID_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_golden,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FID_W-1:0]  s_fid,
    input  logic [7:0]        s_step,
    input  logic [RESP_W-1:0] s_resp,
    input  logic              s_last,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [FID_W-1:0]  r_fid,
    output logic              r_detected,
    output logic [8:0]        r_first_step,
    output logic [8:0]        r_mis_cnt,
    output logic [RESP_W-1:0] r_misr,
    output logic              r_nogold,
    output logic              gold_valid,
    output logic              err_seq
);

    localparam int          AW        = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [7:0]  LAST_STEP = 8'(STEPS - 1);
    localparam logic [8:0]  CNT_MAX   = 9'(STEPS);

    state_e             state_q, state_d;
    logic [7:0]         exp_q, exp_d;
    logic               gold_valid_q, gold_valid_d;
    logic               err_seq_q, err_seq_d;
    logic               nogold_q, nogold_d;
    logic [8:0]         mis_cnt_q, mis_cnt_d;
    logic [8:0]         first_step_q, first_step_d;
    logic [FID_W-1:0]   fid_q, fid_d;

    logic [RESP_W-1:0]  mem [STEPS];
    logic [RESP_W-1:0]  gold_rd;
    logic               accept;
    logic               mismatch;
    logic               ram_we;
    logic               misr_en;
    logic               misr_seed;
    logic               run_beat;
    logic [7:0]         step_nxt;

    assign s_ready  = (state_q != ST_REPORT);
    assign accept   = s_valid && s_ready;
    assign gold_rd  = mem[s_step[AW-1:0]];
    assign mismatch = (s_resp != gold_rd);
    assign step_nxt = (s_step == LAST_STEP) ? 8'd0 : s_step + 8'd1;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        gold_valid_d = gold_valid_q;
        err_seq_d    = err_seq_q;
        nogold_d     = nogold_q;
        mis_cnt_d    = mis_cnt_q;
        first_step_d = first_step_q;
        fid_d        = fid_q;
        ram_we       = 1'b0;
        misr_en      = 1'b0;
        misr_seed    = 1'b0;
        run_beat     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (s_step != 8'd0) begin
                        err_seq_d = 1'b1;
                    end else begin
                        exp_d = step_nxt;
                        if (cfg_golden) begin
                            ram_we = 1'b1;
                            if (s_last) begin
                                gold_valid_d = 1'b1;
                            end else begin
                                state_d = ST_GOLD;
                            end
                        end else begin
                            // Step-0 beat opens a fault pass and is itself compared.
                            fid_d        = s_fid;
                            nogold_d     = !gold_valid_q;
                            mis_cnt_d    = '0;
                            first_step_d = NO_MISMATCH;
                            misr_en      = 1'b1;
                            misr_seed    = 1'b1;
                            run_beat     = 1'b1;
                            state_d      = s_last ? ST_REPORT : ST_RUN;
                        end
                    end
                end
            end
            ST_GOLD: begin
                if (accept) begin
                    if (s_step != exp_q) err_seq_d = 1'b1;
                    exp_d  = step_nxt;
                    ram_we = 1'b1;
                    if (s_last) begin
                        gold_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (s_step != exp_q) err_seq_d = 1'b1;
                    exp_d    = step_nxt;
                    misr_en  = 1'b1;
                    run_beat = 1'b1;
                    if (s_last) state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (r_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Without a golden table nothing is compared, so the record stays clean.
        if (run_beat && !nogold_d && mismatch) begin
            if (first_step_d == NO_MISMATCH) first_step_d = {1'b0, s_step};
            if (mis_cnt_d != CNT_MAX) mis_cnt_d = mis_cnt_d + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            exp_q        <= '0;
            gold_valid_q <= 1'b0;
            err_seq_q    <= 1'b0;
            nogold_q     <= 1'b0;
            mis_cnt_q    <= '0;
            first_step_q <= NO_MISMATCH;
            fid_q        <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            gold_valid_q <= gold_valid_d;
            err_seq_q    <= err_seq_d;
            nogold_q     <= nogold_d;
            mis_cnt_q    <= mis_cnt_d;
            first_step_q <= first_step_d;
            fid_q        <= fid_d;
        end
    end

    // Golden table is deliberately left out of reset; gold_valid gates its use.
    always_ff @(posedge clk) begin
        if (ram_we) mem[s_step[AW-1:0]] <= s_resp;
    end

    resp_misr #(
        .W(RESP_W)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load_seed(misr_seed),
        .en       (misr_en),
        .din      (s_resp),
        .sig      (r_misr)
    );

    assign r_valid      = (state_q == ST_REPORT);
    assign r_fid        = fid_q;
    assign r_detected   = (mis_cnt_q != 9'd0);
    assign r_first_step = first_step_q;
    assign r_mis_cnt    = mis_cnt_q;
    assign r_nogold     = nogold_q;
    assign gold_valid   = gold_valid_q;
    assign err_seq      = err_seq_q;

endmodule

// File: tb/tb_fault_resp_checker.sv
// Directed bench for fault_resp_checker: golden/fault passes, no-golden pass,
// record back-pressure, step-sequence errors and mid-pass reset.
module tb_fault_resp_checker;

    localparam int RESP_W = 28;
    localparam int FID_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_golden;
    logic              s_valid;
    logic              s_ready;
    logic [FID_W-1:0]  s_fid;
    logic [7:0]        s_step;
    logic [RESP_W-1:0] s_resp;
    logic              s_last;
    logic              r_valid;
    logic              r_ready;
    logic [FID_W-1:0]  r_fid;
    logic              r_detected;
    logic [8:0]        r_first_step;
    logic [8:0]        r_mis_cnt;
    logic [RESP_W-1:0] r_misr;
    logic              r_nogold;
    logic              gold_valid;
    logic              err_seq;

    int          checks = 0;
    int          errors = 0;
    logic [27:0] model;
    logic [27:0] saved_misr;

    fault_resp_checker dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_golden  (cfg_golden),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_fid       (s_fid),
        .s_step      (s_step),
        .s_resp      (s_resp),
        .s_last      (s_last),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_fid       (r_fid),
        .r_detected  (r_detected),
        .r_first_step(r_first_step),
        .r_mis_cnt   (r_mis_cnt),
        .r_misr      (r_misr),
        .r_nogold    (r_nogold),
        .gold_valid  (gold_valid),
        .err_seq     (err_seq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] mstep(input logic [27:0] m, input logic [27:0] d);
        return {m[26:0], 1'b0} ^ (m[27] ? 28'h0000009 : 28'h0) ^ d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one beat at posedge+1 and returns at posedge+1 after it was accepted.
    task automatic beat(input logic [7:0] step, input logic [27:0] resp,
                        input logic [15:0] fid, input logic last, input logic gold);
        int n;
        n          = 0;
        s_valid    = 1'b1;
        s_step     = step;
        s_resp     = resp;
        s_fid      = fid;
        s_last     = last;
        cfg_golden = gold;
        while (!s_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("beat_ready_timeout", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Beats first..255; resp = step*3, optional bit flips, skipped step, early stop.
    task automatic pass(input logic [15:0] fid, input logic gold, input int first,
                        input int fa, input int fb, input int skip, input int stop_at);
        logic [27:0] d;
        for (int i = first; i < 256; i++) begin
            if (i == stop_at) break;
            if (i == skip) continue;
            d = 28'(i * 3);
            if (i == fa || i == fb) d = d ^ 28'h0400001;
            if (i == 0) model = '0;
            model = mstep(model, d);
            beat(8'(i), d, (i == 0) ? fid : (fid ^ 16'hA5A5), (i == 255), gold);
        end
    endtask

    task automatic release_rec();
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cfg_golden = 1'b0;
        s_valid    = 1'b0;
        s_fid      = '0;
        s_step     = '0;
        s_resp     = '0;
        s_last     = 1'b0;
        r_ready    = 1'b0;
        model      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_gold_valid", 64'(gold_valid), 64'd0);
        chk("rst_err_seq", 64'(err_seq), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_first_step", 64'(r_first_step), 64'h100);
        chk("rst_mis_cnt", 64'(r_mis_cnt), 64'd0);
        chk("rst_misr", 64'(r_misr), 64'd0);
        chk("rst_fid", 64'(r_fid), 64'd0);
        chk("rst_nogold", 64'(r_nogold), 64'd0);

        // Fault pass with no golden table stored
        pass(16'd9, 1'b0, 0, -1, -1, -1, -1);
        chk("ng_r_valid", 64'(r_valid), 64'd1);
        chk("ng_nogold", 64'(r_nogold), 64'd1);
        chk("ng_detected", 64'(r_detected), 64'd0);
        chk("ng_mis_cnt", 64'(r_mis_cnt), 64'd0);
        chk("ng_first", 64'(r_first_step), 64'h100);
        chk("ng_misr", 64'(r_misr), 64'(model));
        chk("ng_fid", 64'(r_fid), 64'd9);
        release_rec();
        chk("ng_released", 64'(r_valid), 64'd0);

        // Golden pass then identical fault pass
        pass(16'd1, 1'b1, 0, -1, -1, -1, -1);
        chk("gold_valid", 64'(gold_valid), 64'd1);
        chk("gold_no_record", 64'(r_valid), 64'd0);
        chk("gold_err_seq", 64'(err_seq), 64'd0);
        pass(16'd5, 1'b0, 0, -1, -1, -1, -1);
        chk("f5_r_valid", 64'(r_valid), 64'd1);
        chk("f5_fid", 64'(r_fid), 64'd5);
        chk("f5_detected", 64'(r_detected), 64'd0);
        chk("f5_mis_cnt", 64'(r_mis_cnt), 64'd0);
        chk("f5_first", 64'(r_first_step), 64'h100);
        chk("f5_misr", 64'(r_misr), 64'(model));
        chk("f5_nogold", 64'(r_nogold), 64'd0);
        release_rec();

        // Fault pass with beats 10 and 200 flipped; s_fid scrambled after step 0
        pass(16'd7, 1'b0, 0, 10, 200, -1, -1);
        chk("f7_r_valid_lat1", 64'(r_valid), 64'd1);
        chk("f7_fid", 64'(r_fid), 64'd7);
        chk("f7_detected", 64'(r_detected), 64'd1);
        chk("f7_first", 64'(r_first_step), 64'd10);
        chk("f7_mis_cnt", 64'(r_mis_cnt), 64'd2);
        chk("f7_misr", 64'(r_misr), 64'(model));
        saved_misr = model;

        // Back-pressure: next pass's step-0 beat waits while the record is held
        s_valid    = 1'b1;
        s_step     = 8'd0;
        s_resp     = 28'd0;
        s_fid      = 16'd11;
        s_last     = 1'b0;
        cfg_golden = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_r_valid", 64'(r_valid), 64'd1);
            chk("bp_first", 64'(r_first_step), 64'd10);
            chk("bp_mis_cnt", 64'(r_mis_cnt), 64'd2);
            chk("bp_misr", 64'(r_misr), 64'(saved_misr));
            chk("bp_fid", 64'(r_fid), 64'd7);
        end
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        chk("bp_rel_r_valid", 64'(r_valid), 64'd0);
        chk("bp_rel_s_ready", 64'(s_ready), 64'd1);
        chk("bp_not_yet_fid", 64'(r_fid), 64'd7);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("bp_accepted_fid", 64'(r_fid), 64'd11);
        model = mstep(28'd0, 28'd0);
        pass(16'd11, 1'b0, 1, -1, -1, -1, -1);
        chk("f11_r_valid", 64'(r_valid), 64'd1);
        chk("f11_mis_cnt", 64'(r_mis_cnt), 64'd0);
        chk("f11_misr", 64'(r_misr), 64'(model));
        chk("f11_err_seq", 64'(err_seq), 64'd0);
        release_rec();

        // IDLE beat at step 3 is dropped and flags a sequence error
        beat(8'd3, 28'h1234567, 16'd99, 1'b0, 1'b0);
        chk("seq_idle_err", 64'(err_seq), 64'd1);
        chk("seq_idle_r_valid", 64'(r_valid), 64'd0);
        chk("seq_idle_s_ready", 64'(s_ready), 64'd1);
        chk("seq_idle_fid", 64'(r_fid), 64'd11);
        pass(16'd13, 1'b0, 0, -1, -1, 5, -1);
        chk("seq_r_valid", 64'(r_valid), 64'd1);
        chk("seq_fid", 64'(r_fid), 64'd13);
        chk("seq_mis_cnt", 64'(r_mis_cnt), 64'd0);
        chk("seq_misr", 64'(r_misr), 64'(model));
        chk("seq_err_sticky", 64'(err_seq), 64'd1);
        release_rec();

        // Reset at step 100 abandons the pass
        pass(16'd15, 1'b0, 0, -1, -1, -1, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_r_valid", 64'(r_valid), 64'd0);
        chk("mrst_gold_valid", 64'(gold_valid), 64'd0);
        chk("mrst_err_seq", 64'(err_seq), 64'd0);
        chk("mrst_s_ready", 64'(s_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_no_record", 64'(r_valid), 64'd0);
        pass(16'd17, 1'b0, 0, -1, -1, -1, -1);
        chk("post_r_valid", 64'(r_valid), 64'd1);
        chk("post_fid", 64'(r_fid), 64'd17);
        chk("post_nogold", 64'(r_nogold), 64'd1);
        chk("post_detected", 64'(r_detected), 64'd0);
        chk("post_misr", 64'(r_misr), 64'(model));
        chk("post_err_seq", 64'(err_seq), 64'd0);
        release_rec();
        chk("post_released", 64'(r_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
